mp64_bus_arbiter: RTL and testbench

Two-master arbiter sharing the single 64-bit memory bus between the instruction-cache refill port (I) and the load/store data port (D). It sits between mp64_icache/LSU and the memory/interconnect.
- Data port wins by default.
- After an I beat completes, I receives short-term affinity so its second refill beat follows without interleaving.
- A wait counter bounds I starvation.
- One transaction is in flight at a time, with no reordering.

---
 rtl/mp64_pkg.sv | 35 +++
 rtl/mp64_arb_prio.sv | 24 ++
 rtl/mp64_bus_arbiter.sv | 160 ++++++++++++++++
 tb/tb_mp64_bus_arbiter.sv | 362 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mp64_pkg.sv
// Shared bus/arbiter encodings for the mp64 memory subsystem.
package mp64_pkg;

  localparam int unsigned BUS_AW = 64;
  localparam int unsigned BUS_DW = 64;

  // Bus ownership as seen by the rest of the system
  typedef enum logic [1:0] {
    ARB_NONE = 2'd0,
    ARB_I    = 2'd1,
    ARB_D    = 2'd2
  } arb_grant_e;

  // Arbiter FSM states; encodings line up with arb_grant_e so grant mirrors state
  typedef enum logic [1:0] {
    ARB_ST_IDLE  = 2'd0,
    ARB_ST_OWN_I = 2'd1,
    ARB_ST_OWN_D = 2'd2
  } arb_state_e;

  // Access size codes
  localparam logic [1:0] BUS_BYTE  = 2'd0;
  localparam logic [1:0] BUS_HALF  = 2'd1;
  localparam logic [1:0] BUS_WORD  = 2'd2;
  localparam logic [1:0] BUS_DWORD = 2'd3;

  // Request payload presented to the downstream bus
  typedef struct packed {
    logic [BUS_AW-1:0] addr;
    logic [BUS_DW-1:0] wdata;
    logic              wen;
    logic [1:0]        size;
  } bus_req_t;

endpackage

// File: rtl/mp64_arb_prio.sv
// Combinational winner select for the I/D bus arbiter.
module mp64_arb_prio
  import mp64_pkg::*;
(
  input  logic       i_valid,
  input  logic       d_valid,
  input  logic       affinity_nz,
  input  logic       wait_expired,
  output logic [1:0] winner
);

  // Starved or affine I first, then D, then plain I; a forced grant still needs a live request
  always_comb begin
    winner = ARB_NONE;
    if (i_valid && (wait_expired || affinity_nz)) begin
      winner = ARB_I;
    end else if (d_valid) begin
      winner = ARB_D;
    end else if (i_valid) begin
      winner = ARB_I;
    end
  end

endmodule

// File: rtl/mp64_bus_arbiter.sv
// Two-master (icache refill / load-store) arbiter for the shared 64-bit memory bus.
// Optional build macro MP64_ARB_STATS_EN adds grant and I-stall statistics counters.
module mp64_bus_arbiter
  import mp64_pkg::*;
#(
  parameter int unsigned AFFINITY_CYC = 4,
  parameter int unsigned MAX_WAIT     = 8,
  parameter int unsigned WAIT_W       = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_valid,
  input  logic [63:0] i_addr,
  input  logic        i_wen,
  input  logic [1:0]  i_size,
  output logic [63:0] i_rdata,
  output logic        i_ready,
  input  logic        d_valid,
  input  logic [63:0] d_addr,
  input  logic [63:0] d_wdata,
  input  logic        d_wen,
  input  logic [1:0]  d_size,
  output logic [63:0] d_rdata,
  output logic        d_ready,
  output logic        m_valid,
  output logic [63:0] m_addr,
  output logic [63:0] m_wdata,
  output logic        m_wen,
  output logic [1:0]  m_size,
  input  logic [63:0] m_rdata,
  input  logic        m_ready,
  output logic [1:0]  grant,
  output logic        busy
`ifdef MP64_ARB_STATS_EN
  ,
  output logic [63:0] stat_i_grants,
  output logic [63:0] stat_d_grants,
  output logic [63:0] stat_i_stall_cyc
`endif
);

  arb_state_e        state_q, state_d;
  logic [WAIT_W-1:0] aff_q, wait_q;
  logic              busy_q;
  logic [1:0]        winner;
  logic              aff_nz, wait_exp;
  logic              grant_i, grant_d, i_done;
  bus_req_t          m_req;

  assign aff_nz   = (aff_q != '0);
  assign wait_exp = (wait_q >= WAIT_W'(MAX_WAIT));

  mp64_arb_prio u_prio (
    .i_valid      (i_valid),
    .d_valid      (d_valid),
    .affinity_nz  (aff_nz),
    .wait_expired (wait_exp),
    .winner       (winner)
  );

  // Next-state select and owner-side bus mux
  always_comb begin
    state_d = state_q;
    grant_i = 1'b0;
    grant_d = 1'b0;
    i_done  = 1'b0;
    m_valid = 1'b0;
    m_req   = '0;
    i_ready = 1'b0;
    i_rdata = '0;
    d_ready = 1'b0;
    d_rdata = '0;
    unique case (state_q)
      ARB_ST_IDLE: begin
        if (winner == ARB_I) begin
          state_d = ARB_ST_OWN_I;
          grant_i = 1'b1;
        end else if (winner == ARB_D) begin
          state_d = ARB_ST_OWN_D;
          grant_d = 1'b1;
        end
      end
      ARB_ST_OWN_I: begin
        m_valid = i_valid;
        m_req   = '{addr: i_addr, wdata: '0, wen: i_wen, size: i_size};
        i_ready = i_valid && m_ready;
        i_rdata = m_rdata;
        i_done  = i_valid && m_ready;
        // Completion or abort both hand the bus back
        if (!i_valid || m_ready) state_d = ARB_ST_IDLE;
      end
      ARB_ST_OWN_D: begin
        m_valid = d_valid;
        m_req   = '{addr: d_addr, wdata: d_wdata, wen: d_wen, size: d_size};
        d_ready = d_valid && m_ready;
        d_rdata = m_rdata;
        if (!d_valid || m_ready) state_d = ARB_ST_IDLE;
      end
      default: state_d = ARB_ST_IDLE;
    endcase
  end

  assign m_addr  = m_req.addr;
  assign m_wdata = m_req.wdata;
  assign m_wen   = m_req.wen;
  assign m_size  = m_req.size;
  assign grant   = 2'(state_q);
  assign busy    = busy_q;

  // Ownership register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ARB_ST_IDLE;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= (state_d != ARB_ST_IDLE);
    end
  end

  // I affinity window: opened by an I completion, drains outside OWN_I, closed by a D grant
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aff_q <= '0;
    end else if (grant_d) begin
      aff_q <= '0;
    end else if (i_done) begin
      aff_q <= WAIT_W'(AFFINITY_CYC);
    end else if (aff_nz && state_q != ARB_ST_OWN_I) begin
      aff_q <= aff_q - WAIT_W'(1);
    end
  end

  // I starvation counter, saturating
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_q <= '0;
    end else if (!i_valid || grant_i) begin
      wait_q <= '0;
    end else if (state_q != ARB_ST_OWN_I && wait_q != '1) begin
      wait_q <= wait_q + WAIT_W'(1);
    end
  end

`ifdef MP64_ARB_STATS_EN
  // Grant and I-stall statistics
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_i_grants    <= '0;
      stat_d_grants    <= '0;
      stat_i_stall_cyc <= '0;
    end else begin
      if (grant_i) stat_i_grants <= stat_i_grants + 64'd1;
      if (grant_d) stat_d_grants <= stat_d_grants + 64'd1;
      if (i_valid && state_q != ARB_ST_OWN_I) stat_i_stall_cyc <= stat_i_stall_cyc + 64'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mp64_bus_arbiter.sv
// Self-checking bench for mp64_bus_arbiter: directed scenarios plus randomized
// traffic checked by a reference model feeding an expected-beat scoreboard.
module tb_mp64_bus_arbiter;
  import mp64_pkg::*;

  localparam int AFF  = 4;
  localparam int MAXW = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_valid = 1'b0, i_wen = 1'b0, i_ready;
  logic [63:0] i_addr = '0, i_rdata;
  logic [1:0]  i_size = '0;
  logic        d_valid = 1'b0, d_wen = 1'b0, d_ready;
  logic [63:0] d_addr = '0, d_wdata = '0, d_rdata;
  logic [1:0]  d_size = '0;
  logic        m_valid, m_wen, m_ready = 1'b0;
  logic [63:0] m_addr, m_wdata, m_rdata = '0;
  logic [1:0]  m_size, grant;
  logic        busy;
`ifdef MP64_ARB_STATS_EN
  logic [63:0] stat_i_grants, stat_d_grants, stat_i_stall_cyc;
`endif

  mp64_bus_arbiter #(.AFFINITY_CYC(AFF), .MAX_WAIT(MAXW), .WAIT_W(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_valid(i_valid), .i_addr(i_addr), .i_wen(i_wen), .i_size(i_size),
    .i_rdata(i_rdata), .i_ready(i_ready),
    .d_valid(d_valid), .d_addr(d_addr), .d_wdata(d_wdata), .d_wen(d_wen),
    .d_size(d_size), .d_rdata(d_rdata), .d_ready(d_ready),
    .m_valid(m_valid), .m_addr(m_addr), .m_wdata(m_wdata), .m_wen(m_wen),
    .m_size(m_size), .m_rdata(m_rdata), .m_ready(m_ready),
    .grant(grant), .busy(busy)
`ifdef MP64_ARB_STATS_EN
    ,
    .stat_i_grants(stat_i_grants), .stat_d_grants(stat_d_grants),
    .stat_i_stall_cyc(stat_i_stall_cyc)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  // ---------------- reference model (cycle-level rules, counted in elapsed cycles) ----------------
  typedef struct {
    int          who;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic        wen;
    logic [1:0]  size;
  } exp_t;

  exp_t        exp_q[$];
  int          m_owner = 0;     // 0 none, 1 I, 2 D
  int          m_starve = 0;    // consecutive cycles I has asked without owning the bus
  bit          m_aff_live = 0;  // an I completion happened and no D grant since
  int          m_aff_idle = 0;  // non-OWN_I cycles since that completion
  longint      m_igr = 0, m_dgr = 0, m_stall = 0;

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_owner = 0; m_starve = 0; m_aff_live = 0; m_aff_idle = 0;
      m_igr = 0; m_dgr = 0; m_stall = 0;
      exp_q.delete();
    end else begin
      bit gi, gd, done_i;
      int nxt;
      gi = 0; gd = 0; done_i = 0; nxt = m_owner;
      if (i_valid && m_owner != 1) m_stall++;
      if (m_owner == 0) begin
        if (i_valid && (m_starve >= MAXW || (m_aff_live && m_aff_idle < AFF))) gi = 1;
        else if (d_valid) gd = 1;
        else if (i_valid) gi = 1;
      end else if (m_owner == 1) begin
        if (!i_valid) begin void'(exp_q.pop_front()); nxt = 0; end
        else if (m_ready) begin done_i = 1; nxt = 0; end
      end else begin
        if (!d_valid) begin void'(exp_q.pop_front()); nxt = 0; end
        else if (m_ready) nxt = 0;
      end
      if (gi) begin
        nxt = 1; m_igr++;
        exp_q.push_back('{who: 1, addr: i_addr, wdata: 64'd0, wen: i_wen, size: i_size});
      end
      if (gd) begin
        nxt = 2; m_dgr++;
        exp_q.push_back('{who: 2, addr: d_addr, wdata: d_wdata, wen: d_wen, size: d_size});
      end
      if (!i_valid || gi) m_starve = 0;
      else if (m_owner != 1) m_starve++;
      if (gd) m_aff_live = 0;
      else if (done_i) begin m_aff_live = 1; m_aff_idle = 0; end
      else if (m_aff_live && m_owner != 1) m_aff_idle++;
      m_owner = nxt;
    end
  end

  // ---------------- monitor / scoreboard ----------------
  exp_t mon_e;
  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      chk("grant", 64'(grant), 64'(m_owner));
      chk("busy", 64'(busy), 64'(m_owner != 0));
      chk("m_valid", 64'(m_valid), 64'((m_owner == 1 && i_valid) || (m_owner == 2 && d_valid)));
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL beat_unexpected actual=beat expected=none t=%0t", $time);
        end else begin
          mon_e = exp_q.pop_front();
          chk("beat_owner", 64'(grant), 64'(mon_e.who));
          chk("beat_addr", m_addr, mon_e.addr);
          chk("beat_wdata", m_wdata, mon_e.wdata);
          chk("beat_wen", 64'(m_wen), 64'(mon_e.wen));
          chk("beat_size", 64'(m_size), 64'(mon_e.size));
          if (mon_e.who == 1) begin
            chk("i_ready_beat", 64'(i_ready), 64'd1);
            chk("i_rdata_beat", i_rdata, m_rdata);
            chk("d_ready_other", 64'(d_ready), 64'd0);
            chk("d_rdata_other", d_rdata, 64'd0);
          end else begin
            chk("d_ready_beat", 64'(d_ready), 64'd1);
            chk("d_rdata_beat", d_rdata, m_rdata);
            chk("i_ready_other", 64'(i_ready), 64'd0);
            chk("i_rdata_other", i_rdata, 64'd0);
          end
        end
      end else begin
        chk("ready_no_beat", 64'({i_ready, d_ready}), 64'd0);
      end
    end
  end

  // One complete transaction from a single master with an always-ready downstream
  task automatic do_txn(input int who, input logic [63:0] a);
    bit ok;
    step();
    m_ready = 1'b1;
    m_rdata = {$urandom, $urandom};
    if (who == 1) begin i_valid = 1'b1; i_addr = a; i_size = BUS_DWORD; end
    else begin d_valid = 1'b1; d_addr = a; d_wdata = {$urandom, $urandom}; d_wen = 1'b1; d_size = BUS_DWORD; end
    ok = 0;
    for (int k = 0; k < 20 && !ok; k++) begin
      @(negedge clk);
      if ((who == 1 && i_ready) || (who == 2 && d_ready)) ok = 1;
    end
    chk("txn_done_in_time", 64'(ok), 64'd1);
    step();
    i_valid = 1'b0; d_valid = 1'b0; m_ready = 1'b0;
  endtask

  initial begin
    int got;
    bit ir, dr;

    // Reset state
    idle(3);
    @(negedge clk);
    chk("rst_grant", 64'(grant), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_m_valid", 64'(m_valid), 64'd0);
    chk("rst_m_addr", m_addr, 64'd0);
    chk("rst_m_wdata", m_wdata, 64'd0);
    chk("rst_m_wen", 64'(m_wen), 64'd0);
    chk("rst_m_size", 64'(m_size), 64'd0);
    chk("rst_readies", 64'({i_ready, d_ready}), 64'd0);
    step();
    rst_n = 1'b1;
    idle(2);

    // I only, earliest latency and read return
    i_valid = 1'b1; i_addr = 64'h100; i_size = BUS_DWORD;
    @(negedge clk);
    chk("ionly_no_early_valid", 64'(m_valid), 64'd0);
    step();
    @(negedge clk);
    chk("ionly_m_valid", 64'(m_valid), 64'd1);
    chk("ionly_m_addr", m_addr, 64'h100);
    chk("ionly_grant", 64'(grant), 64'(ARB_I));
    chk("ionly_m_wdata", m_wdata, 64'd0);
    step();
    m_ready = 1'b1; m_rdata = 64'hAAAABBBBCCCCDDDD;
    @(negedge clk);
    chk("ionly_i_ready", 64'(i_ready), 64'd1);
    chk("ionly_i_rdata", i_rdata, 64'hAAAABBBBCCCCDDDD);
    step();
    i_valid = 1'b0; m_ready = 1'b0;
    @(negedge clk);
    chk("ionly_release", 64'(grant), 64'(ARB_NONE));
    idle(6);

    // Simultaneous requests: D first, I after one bubble
    i_valid = 1'b1; i_addr = 64'h200;
    d_valid = 1'b1; d_addr = 64'h300; d_wdata = 64'h1234_5678_9ABC_DEF0; d_wen = 1'b1; d_size = BUS_WORD;
    @(negedge clk);
    chk("sim_idle", 64'(grant), 64'd0);
    step();
    m_ready = 1'b1;
    @(negedge clk);
    chk("sim_grant_d", 64'(grant), 64'(ARB_D));
    chk("sim_m_addr", m_addr, 64'h300);
    chk("sim_m_wen", 64'(m_wen), 64'd1);
    chk("sim_m_wdata", m_wdata, 64'h1234_5678_9ABC_DEF0);
    step();
    d_valid = 1'b0; d_wen = 1'b0;
    @(negedge clk);
    chk("sim_bubble", 64'(grant), 64'(ARB_NONE));
    step();
    @(negedge clk);
    chk("sim_grant_i", 64'(grant), 64'(ARB_I));
    chk("sim_i_addr", m_addr, 64'h200);
    step();
    i_valid = 1'b0; m_ready = 1'b0;
    idle(6);

    // Affinity: I beat1 beats a concurrent D request
    i_valid = 1'b1; i_addr = 64'h100; i_size = BUS_DWORD; m_ready = 1'b1; m_rdata = {$urandom, $urandom};
    step();
    @(negedge clk);
    chk("aff_beat0_ready", 64'(i_ready), 64'd1);
    step();
    i_addr = 64'h108; d_valid = 1'b1; d_addr = 64'h500; d_wen = 1'b0; d_size = BUS_DWORD;
    step();
    @(negedge clk);
    chk("aff_grant_i", 64'(grant), 64'(ARB_I));
    chk("aff_addr", m_addr, 64'h108);
    step();
    i_valid = 1'b0;
    step();
    @(negedge clk);
    chk("aff_then_d", 64'(grant), 64'(ARB_D));
    chk("aff_d_addr", m_addr, 64'h500);
    step();
    d_valid = 1'b0; m_ready = 1'b0;
    idle(6);

    // Starvation bound: D hammers the bus, I must still get in
    d_valid = 1'b1; d_addr = 64'h4000; d_size = BUS_DWORD; m_ready = 1'b1;
    i_valid = 1'b1; i_addr = 64'h700;
    got = -1;
    for (int k = 0; k <= MAXW + 4; k++) begin
      @(negedge clk);
      if (grant == ARB_I && got < 0) got = k;
      ir = i_ready; dr = d_ready;
      step();
      if (dr) d_addr = d_addr + 64'd8;
      if (ir) i_valid = 1'b0;
    end
    chk("starve_granted_in_bound", 64'(got >= 0 && got <= MAXW + 2), 64'd1);
    d_valid = 1'b0; i_valid = 1'b0; m_ready = 1'b0;
    idle(6);

    // Abort: D drops its request before any ready
    d_valid = 1'b1; d_addr = 64'h900; d_wen = 1'b1; d_wdata = 64'h55; m_ready = 1'b0;
    step();
    @(negedge clk);
    chk("abort_grant_d", 64'(grant), 64'(ARB_D));
    step();
    d_valid = 1'b0;
    @(negedge clk);
    chk("abort_m_valid", 64'(m_valid), 64'd0);
    chk("abort_d_ready", 64'(d_ready), 64'd0);
    step();
    @(negedge clk);
    chk("abort_released", 64'(grant), 64'(ARB_NONE));
    chk("abort_d_ready2", 64'(d_ready), 64'd0);
    idle(2);

    // Asynchronous reset in the middle of an I ownership
    i_valid = 1'b1; i_addr = 64'h140; m_ready = 1'b0;
    step();
    @(negedge clk);
    chk("areset_owned", 64'(grant), 64'(ARB_I));
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("areset_m_valid", 64'(m_valid), 64'd0);
    chk("areset_grant", 64'(grant), 64'd0);
    chk("areset_busy", 64'(busy), 64'd0);
    chk("areset_m_addr", m_addr, 64'd0);
    i_valid = 1'b0;
    idle(2);
    rst_n = 1'b1;
    idle(1);

    // Three I grants then two D grants
    for (int k = 0; k < 3; k++) do_txn(1, 64'h1000 + 64'(k * 8));
    for (int k = 0; k < 2; k++) do_txn(2, 64'h2000 + 64'(k * 8));
    idle(2);
`ifdef MP64_ARB_STATS_EN
    chk("stat_i_grants", stat_i_grants, 64'd3);
    chk("stat_d_grants", stat_d_grants, 64'd2);
    chk("stat_i_stall", stat_i_stall_cyc, 64'd3);
`endif

    // Randomized traffic from compliant masters and a random-latency downstream
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      ir = i_ready; dr = d_ready;
      step();
      if (!i_valid || ir) begin
        if ($urandom_range(0, 99) < 40) begin
          i_valid = 1'b1; i_addr = {$urandom, $urandom}; i_size = 2'($urandom_range(0, 3));
          i_wen = 1'b0;
        end else i_valid = 1'b0;
      end
      if (!d_valid || dr) begin
        if ($urandom_range(0, 99) < 70) begin
          d_valid = 1'b1; d_addr = {$urandom, $urandom}; d_wdata = {$urandom, $urandom};
          d_wen = 1'($urandom_range(0, 1)); d_size = 2'($urandom_range(0, 3));
        end else d_valid = 1'b0;
      end
      m_ready = ($urandom_range(0, 99) < 60);
      m_rdata = {$urandom, $urandom};
    end

    // Drain outstanding requests cleanly
    for (int k = 0; k < 50 && (i_valid || d_valid); k++) begin
      @(negedge clk);
      ir = i_ready; dr = d_ready;
      step();
      m_ready = 1'b1;
      if (ir) i_valid = 1'b0;
      if (dr) d_valid = 1'b0;
    end
    chk("drain_done", 64'({i_valid, d_valid}), 64'd0);
    m_ready = 1'b0;
    idle(3);
    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
`ifdef MP64_ARB_STATS_EN
    chk("stat_i_grants_model", stat_i_grants, 64'(m_igr));
    chk("stat_d_grants_model", stat_d_grants, 64'(m_dgr));
    chk("stat_stall_model", stat_i_stall_cyc, 64'(m_stall));
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
